// File: rtl/maj_chain_serial_eval.sv
// Bit-serial evaluator for the majority-chain benchmark: one 3-bit group per beat,
// group majorities folded through a left-leaning MAJ chain, one result per frame.
module maj_chain_serial_eval #(
  parameter int NUM_GROUPS = 6,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_bits,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_result,
  output logic       out_frame_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_GROUPS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             prev_q, prev_d;
  logic             g0_q, g0_d;
  logic             g1_q, g1_d;
  logic             err_q, err_d;

  logic accept;
  logic m;
  logic lastBeat;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  assign in_ready      = (state_q != OUT);
  assign out_valid     = (state_q == OUT);
  assign busy          = (state_q != IDLE);
  assign out_result    = acc_q;
  assign out_frame_err = err_q;

  assign accept   = in_valid && in_ready;
  assign m        = maj3(in_bits[0], in_bits[1], in_bits[2]);
  assign lastBeat = (state_q == ACCUM) && (cnt_q == LAST_IDX);

  // Groups 0 and 1 are parked until group 2 arrives to seed the chain.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    prev_d  = prev_q;
    g0_d    = g0_q;
    g1_d    = g1_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          g0_d    = m;
          cnt_d   = CNT_W'(1);
          err_d   = in_last;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (cnt_q == CNT_W'(1)) begin
            g1_d = m;
          end else if (cnt_q == CNT_W'(2)) begin
            acc_d  = maj3(g0_q, g1_q, m);
            prev_d = m;
          end else begin
            acc_d  = maj3(acc_q, prev_q, m);
            prev_d = m;
          end
          err_d = err_q | (in_last != lastBeat);
          if (lastBeat) begin
            state_d = OUT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      prev_q  <= 1'b0;
      g0_q    <= 1'b0;
      g1_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      prev_q  <= prev_d;
      g0_q    <= g0_d;
      g1_q    <= g1_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_maj_chain_serial_eval.sv
// Self-checking bench for maj_chain_serial_eval: directed frames plus a randomized
// 64-pattern sweep compared against a formula-level reference model.
module tb_maj_chain_serial_eval;

  localparam int N = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_bits = 3'b000;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_result;
  logic       out_frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  maj_chain_serial_eval #(.NUM_GROUPS(N), .CNT_W(3)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_bits(in_bits),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_result(out_result),
    .out_frame_err(out_frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Majority by counting ones, independent of any gate-level form.
  function automatic logic majCount(input logic a, input logic b, input logic c);
    int s;
    s = int'(a) + int'(b) + int'(c);
    return (s >= 2);
  endfunction

  // Reference: result = MAJ(...MAJ(MAJ(w0,w1,w2),w2,w3)...,w[N-2],w[N-1]).
  function automatic logic refResult(input logic [N-1:0] w);
    logic r;
    r = majCount(w[0], w[1], w[2]);
    for (int i = 3; i < N; i++) r = majCount(r, w[i-1], w[i]);
    return r;
  endfunction

  // Random group whose majority equals w (inverting a group flips its majority).
  function automatic logic [2:0] encodeGroup(input logic w);
    logic [2:0] b;
    b = 3'($urandom);
    if (majCount(b[0], b[1], b[2]) != w) b = ~b;
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] bits, input logic last);
    in_valid = 1'b1;
    in_bits  = bits;
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bits  = 3'($urandom);
    in_last  = 1'($urandom);
  endtask

  // Sends N beats; lastPos marks which beat carries in_last (-1 for none).
  task automatic sendFrame(input logic [N-1:0] w, input int lastPos, input bit gaps);
    for (int k = 0; k < N; k++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        @(posedge clk);
        #1;
        checkOutput("gap_busy", busy, (k != 0));
      end
      applyStimulus(encodeGroup(w[k]), (k == lastPos));
    end
  endtask

  task automatic consumeResult(input string tag, input logic expR, input logic expE);
    checkOutput({tag, "_valid"}, out_valid, 1'b1);
    checkOutput({tag, "_result"}, out_result, expR);
    checkOutput({tag, "_err"}, out_frame_err, expE);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput({tag, "_drop"}, out_valid, 1'b0);
    checkOutput({tag, "_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [N-1:0] w;
    logic held;

    // Reset state, both while asserted and after release.
    #12;
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_result", out_result, 1'b0);
    checkOutput("rst_err", out_frame_err, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_busy", busy, 1'b0);

    // All-ones frame.
    for (int k = 0; k < N; k++) begin
      applyStimulus(3'b111, (k == N - 1));
      if (k < N - 1) checkOutput("ones_busy", busy, 1'b1);
    end
    consumeResult("ones", 1'b1, 1'b0);

    // Reference vector with literal groups: w = 1,1,0,0,1,0.
    applyStimulus(3'b011, 1'b0);
    applyStimulus(3'b110, 1'b0);
    applyStimulus(3'b001, 1'b0);
    applyStimulus(3'b100, 1'b0);
    applyStimulus(3'b101, 1'b0);
    applyStimulus(3'b000, 1'b1);
    consumeResult("refvec", 1'b0, 1'b0);

    // Second vector w = 0,0,1,1,1,0 (bit k = w_k).
    sendFrame(6'b011100, N - 1, 1'b0);
    consumeResult("vec2", 1'b1, 1'b0);

    // Sweep every w-pattern with random group encodings and idle gaps.
    for (int p = 0; p < 64; p++) begin
      w = 6'(p);
      sendFrame(w, N - 1, 1'b1);
      consumeResult("sweep", refResult(w), 1'b0);
    end

    // Backpressure: result held, input blocked even with in_valid asserted.
    w = 6'b101101;
    sendFrame(w, N - 1, 1'b0);
    held = refResult(w);
    in_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_bits = 3'($urandom);
      @(posedge clk);
      #1;
      checkOutput("bp_in_ready", in_ready, 1'b0);
      checkOutput("bp_valid", out_valid, 1'b1);
      checkOutput("bp_result", out_result, held);
    end
    in_valid = 1'b0;
    consumeResult("bp", held, 1'b0);
    w = 6'b000111;
    sendFrame(w, N - 1, 1'b0);
    consumeResult("post_bp", refResult(w), 1'b0);

    // Framing errors: early in_last, then missing in_last, then a clean frame.
    w = 6'($urandom);
    sendFrame(w, 2, 1'b0);
    consumeResult("err_early", refResult(w), 1'b1);
    w = 6'($urandom);
    sendFrame(w, -1, 1'b0);
    consumeResult("err_missing", refResult(w), 1'b1);
    w = 6'($urandom);
    sendFrame(w, N - 1, 1'b0);
    consumeResult("err_clean", refResult(w), 1'b0);

    // Reset mid-frame after 3 beats of a frame that would otherwise seed g0..acc.
    for (int k = 0; k < 3; k++) applyStimulus(3'b111, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", out_valid, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    checkOutput("midrst_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    w = 6'b010010;
    sendFrame(w, N - 1, 1'b0);
    consumeResult("after_rst", refResult(w), 1'b0);

    // Reset while a result is pending.
    sendFrame(6'b111111, N - 1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("outrst_valid", out_valid, 1'b0);
    checkOutput("outrst_result", out_result, 1'b0);
    checkOutput("outrst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maj_chain_serial_eval.md
Name: maj_chain_serial_eval

Overview:
- Bit-serial evaluator for the 18-input majority-chain benchmark function.
- Accepts one 3-bit input group per beat over a valid/ready stream.
- Folds the group majorities through the same left-leaning majority chain and emits one result bit per frame over an output valid/ready handshake.
- Serves as the streaming counterpart to the flat combinational netlist. It is the golden/consumer end used by benchmark harnesses that send patterns serially.

Parameters:
- NUM_GROUPS, 6, groups per frame; must be >= 3. Default 6 matches the 18-input function.
- CNT_W, 3, group counter width; must satisfy 2^CNT_W >= NUM_GROUPS.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input group valid
- in_ready  output  1  evaluator can accept a group
- in_bits  input  3  group bits {pi(3k+2), pi(3k+1), pi(3k)}
- in_last  input  1  sender marks final group of frame
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_result  output  1  majority-chain result (po0)
- out_frame_err  output  1  in_last disagreed with internal count for this frame
- busy  output  1  frame in progress or result pending

Behaviour:
- Reset (async assert, sync release): state=IDLE, cnt=0, acc=0, prev=0, g0=0, g1=0. Outputs: in_ready=1, out_valid=0, out_result=0, out_frame_err=0, busy=0.
- Beat accepted when in_valid && in_ready. m = MAJ(in_bits[0], in_bits[1], in_bits[2]).
- Fold rule at beat index k:
  - k=0: g0<=m.
  - k=1: g1<=m.
  - k=2: acc<=MAJ(g0, g1, m); prev<=m.
  - k>=3: acc<=MAJ(acc, prev, m); prev<=m.
- Resulting function for N=6: result = MAJ(MAJ(MAJ(MAJ(w0,w1,w2),w2,w3),w3,w4),w4,w5).
- States:
  - IDLE: in_ready=1, busy=0. First accepted beat -> ACCUM with cnt=1.
  - ACCUM: in_ready=1, busy=1. Each accepted beat increments cnt. The beat with k=NUM_GROUPS-1 -> OUT.
  - OUT: in_ready=0, out_valid=1, busy=1. out_result and out_frame_err are held stable until out_ready. On out_valid && out_ready -> IDLE, clear cnt, drop out_valid.
- Latency: out_valid rises in the cycle after the final group is accepted.
- Throughput: one frame per NUM_GROUPS+1 cycles with out_ready tied high. No accept is allowed in the cycle a result is consumed.
- Framing: frame length is fixed by NUM_GROUPS. in_last is only checked, not used for control.
  - out_frame_err=1 if in_last=1 on any beat other than the last.
  - out_frame_err=1 if in_last=0 on the last beat.
  - The error is sticky within the frame and clears on result handshake.
- Stalls: in_valid low holds all state. out_ready low holds OUT indefinitely.
- in_bits and in_last are ignored when in_valid=0.
- Async reset mid-frame or mid-OUT: partial frame discarded, all outputs return to reset values immediately.
- cnt never exceeds NUM_GROUPS-1. No wrap occurs because OUT blocks input.

Test Plan:
- All-ones frame: 6 beats of in_bits=3'b111, in_last on beat 5 -> out_valid one cycle after beat 5, out_result=1, out_frame_err=0.
- Reference vector: group majorities w0..w5 = 1,1,0,0,1,0 (in_bits 011,110,001,100,101,000) -> out_result=0.
- Second vector: w0..w5 = 0,0,1,1,1,0 -> out_result=1. Also sweep all 64 w-patterns against the formula.
- Backpressure: hold out_ready=0 for 10 cycles -> in_ready=0 and out_result stable throughout. Then pulse out_ready for 1 cycle -> IDLE next cycle, in_ready=1.
- Framing error: in_last=1 on beat 2 -> out_frame_err=1 with the result. The next clean frame gives out_frame_err=0.
- Reset mid-frame: assert rst_n=0 after 3 beats -> out_valid=0 and busy=0 immediately. A fresh 6-beat frame afterwards evaluates correctly with no leftover state.
